// File: rtl/nonce_sweep_ctrl.sv
// Nonce sweep sequencer for sha256_module: issues one hash per nonce, stops on hit/end/abort.
// Optional hash counter enabled by defining NONCE_SWEEP_STATS_EN (otherwise hash_count is 0).
module nonce_sweep_ctrl #(
    parameter int NONCE_WORD = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [511:0] cfg_block,
    input  logic [31:0]  cfg_nonce_start,
    input  logic [31:0]  cfg_nonce_end,
    input  logic [255:0] cfg_target,
    input  logic         go,
    input  logic         abort,
    output logic         core_start,
    output logic [511:0] core_data,
    input  logic         core_done,
    input  logic [255:0] core_hash,
    output logic         busy,
    output logic         found,
    output logic         exhausted,
    output logic         aborted,
    output logic [31:0]  found_nonce,
    output logic [255:0] found_hash,
    output logic [31:0]  cur_nonce,
    output logic [31:0]  hash_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_CHECK = 2'd3;

    localparam int NONCE_LSB = 32 * NONCE_WORD;

    logic [1:0]   state_q,       state_d;
    logic [511:0] block_q,       block_d;
    logic [31:0]  end_q,         end_d;
    logic [255:0] target_q,      target_d;
    logic [31:0]  cur_nonce_q,   cur_nonce_d;
    logic [511:0] core_data_q,   core_data_d;
    logic [255:0] hash_q,        hash_d;
    logic         abort_pend_q,  abort_pend_d;
    logic         found_q,       found_d;
    logic         exhausted_q,   exhausted_d;
    logic         aborted_q,     aborted_d;
    logic [31:0]  found_nonce_q, found_nonce_d;
    logic [255:0] found_hash_q,  found_hash_d;

    function automatic logic [511:0] insert_nonce(input logic [511:0] blk, input logic [31:0] n);
        logic [511:0] r;
        r = blk;
        r[NONCE_LSB +: 32] = n;
        return r;
    endfunction

    // NOTE: every _d gets a default first so no path through the case can infer a latch.
    always_comb begin
        state_d       = state_q;
        block_d       = block_q;
        end_d         = end_q;
        target_d      = target_q;
        cur_nonce_d   = cur_nonce_q;
        core_data_d   = core_data_q;
        hash_d        = hash_q;
        abort_pend_d  = abort_pend_q;
        found_d       = found_q;
        exhausted_d   = exhausted_q;
        aborted_d     = aborted_q;
        found_nonce_d = found_nonce_q;
        found_hash_d  = found_hash_q;

        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d      = ST_ISSUE;
                    block_d      = cfg_block;
                    end_d        = cfg_nonce_end;
                    target_d     = cfg_target;
                    cur_nonce_d  = cfg_nonce_start;
                    core_data_d  = insert_nonce(cfg_block, cfg_nonce_start);
                    abort_pend_d = 1'b0;
                    found_d      = 1'b0;
                    exhausted_d  = 1'b0;
                    aborted_d    = 1'b0;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                if (abort) abort_pend_d = 1'b1;
            end
            ST_WAIT: begin
                if (abort) abort_pend_d = 1'b1;
                if (core_done) begin
                    hash_d  = core_hash;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                // An abort raised in this very cycle still wins over the compare.
                if (abort_pend_q || abort) begin
                    state_d      = ST_IDLE;
                    aborted_d    = 1'b1;
                    abort_pend_d = 1'b0;
                end else if (hash_q < target_q) begin
                    state_d       = ST_IDLE;
                    found_d       = 1'b1;
                    found_nonce_d = cur_nonce_q;
                    found_hash_d  = hash_q;
                end else if (cur_nonce_q == end_q) begin
                    state_d     = ST_IDLE;
                    exhausted_d = 1'b1;
                end else begin
                    state_d     = ST_ISSUE;
                    cur_nonce_d = cur_nonce_q + 32'd1;
                    core_data_d = insert_nonce(block_q, cur_nonce_q + 32'd1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            block_q       <= '0;
            end_q         <= '0;
            target_q      <= '0;
            cur_nonce_q   <= '0;
            core_data_q   <= '0;
            hash_q        <= '0;
            abort_pend_q  <= 1'b0;
            found_q       <= 1'b0;
            exhausted_q   <= 1'b0;
            aborted_q     <= 1'b0;
            found_nonce_q <= '0;
            found_hash_q  <= '0;
        end else begin
            state_q       <= state_d;
            block_q       <= block_d;
            end_q         <= end_d;
            target_q      <= target_d;
            cur_nonce_q   <= cur_nonce_d;
            core_data_q   <= core_data_d;
            hash_q        <= hash_d;
            abort_pend_q  <= abort_pend_d;
            found_q       <= found_d;
            exhausted_q   <= exhausted_d;
            aborted_q     <= aborted_d;
            found_nonce_q <= found_nonce_d;
            found_hash_q  <= found_hash_d;
        end
    end

`ifdef NONCE_SWEEP_STATS_EN
    logic [31:0] hash_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hash_count_q <= '0;
        end else if (state_q == ST_IDLE && go) begin
            hash_count_q <= '0;
        end else if (state_q == ST_WAIT && core_done && hash_count_q != 32'hFFFF_FFFF) begin
            hash_count_q <= hash_count_q + 32'd1;
        end
    end

    assign hash_count = hash_count_q;
`else
    assign hash_count = '0;
`endif

    assign core_start  = (state_q == ST_ISSUE);
    assign busy        = (state_q != ST_IDLE);
    assign core_data   = core_data_q;
    assign cur_nonce   = cur_nonce_q;
    assign found       = found_q;
    assign exhausted   = exhausted_q;
    assign aborted     = aborted_q;
    assign found_nonce = found_nonce_q;
    assign found_hash  = found_hash_q;

endmodule

// File: tb/tb_nonce_sweep_ctrl.sv
// Directed bench for nonce_sweep_ctrl with a fixed-latency sha256 stub and an issue scoreboard.
module tb_nonce_sweep_ctrl;

    localparam int LAT = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic [511:0] cfg_block;
    logic [31:0]  cfg_nonce_start;
    logic [31:0]  cfg_nonce_end;
    logic [255:0] cfg_target;
    logic         go;
    logic         abort;
    logic         core_start;
    logic [511:0] core_data;
    logic         core_done;
    logic [255:0] core_hash;
    logic         busy;
    logic         found;
    logic         exhausted;
    logic         aborted;
    logic [31:0]  found_nonce;
    logic [255:0] found_hash;
    logic [31:0]  cur_nonce;
    logic [31:0]  hash_count;

    int total = 0;
    int bad   = 0;
    int start_cnt = 0;
    logic [511:0] sb[$];
    logic [511:0] tmpl;

    // Stub core: not reset, so a hash in flight across a DUT reset still completes.
    logic [31:0] stub_nonce = '0;
    int          stub_cnt = 0;
    logic        stub_act = 1'b0;
    logic        hash_mode = 1'b0;

    always #5 clk = ~clk;

    nonce_sweep_ctrl #(.NONCE_WORD(3)) dut (
        .clk(clk), .reset(reset),
        .cfg_block(cfg_block), .cfg_nonce_start(cfg_nonce_start),
        .cfg_nonce_end(cfg_nonce_end), .cfg_target(cfg_target),
        .go(go), .abort(abort),
        .core_start(core_start), .core_data(core_data),
        .core_done(core_done), .core_hash(core_hash),
        .busy(busy), .found(found), .exhausted(exhausted), .aborted(aborted),
        .found_nonce(found_nonce), .found_hash(found_hash),
        .cur_nonce(cur_nonce), .hash_count(hash_count)
    );

    always @(posedge clk) begin
        if (core_start) begin
            stub_act   <= 1'b1;
            stub_cnt   <= LAT;
            stub_nonce <= core_data[96 +: 32];
        end else if (stub_act) begin
            if (stub_cnt == 1) stub_act <= 1'b0;
            stub_cnt <= stub_cnt - 1;
        end
    end

    assign core_done = stub_act && (stub_cnt == 1);
    assign core_hash = hash_mode ? {32'd22 - stub_nonce, 224'h0} : 256'h1;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] blk_with(input logic [511:0] b, input logic [31:0] n);
        logic [511:0] r;
        r = b;
        r[96 +: 32] = n;
        return r;
    endfunction

    function automatic logic [31:0] exp_hc(input int n);
`ifdef NONCE_SWEEP_STATS_EN
        return n;
`else
        return (n == 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    // Scoreboard: every core_start pops the block the bench expects to be issued next.
    always @(negedge clk) begin
        if (core_start === 1'b1) begin
            start_cnt++;
            if (sb.size() == 0) begin
                check("sb_unexpected_start", {511'b0, core_start}, 512'b0);
            end else begin
                check("sb_core_data", core_data, sb.pop_front());
            end
        end
    end

    task automatic pulse_go;
        @(negedge clk) go = 1'b1;
        @(negedge clk) go = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy === 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", {511'b0, busy}, 512'b0);
    endtask

    initial begin
        int s0;
        for (int k = 0; k < 16; k++) tmpl[32*k +: 32] = 32'hA5C3_0000 + 32'(k * 32'h0101);
        reset = 1'b1; go = 1'b0; abort = 1'b0;
        cfg_block = tmpl; cfg_nonce_start = '0; cfg_nonce_end = '0; cfg_target = '0;

        @(negedge clk);
        check("rst_busy",      {511'b0, busy}, 512'b0);
        check("rst_start",     {511'b0, core_start}, 512'b0);
        check("rst_core_data", core_data, 512'b0);
        check("rst_flags",     {509'b0, found, exhausted, aborted}, 512'b0);
        check("rst_nonce",     {480'b0, cur_nonce}, 512'b0);
        check("rst_fhash",     {256'b0, found_hash}, 512'b0);
        check("rst_count",     {480'b0, hash_count}, 512'b0);
        @(negedge clk) reset = 1'b0;

        // Single nonce hit, exact timing.
        cfg_nonce_start = 32'd5; cfg_nonce_end = 32'd5; cfg_target = '1; hash_mode = 1'b0;
        sb.push_back(blk_with(tmpl, 32'd5));
        s0 = start_cnt;
        @(negedge clk) go = 1'b1;
        @(negedge clk) go = 1'b0;
        check("t1_busy_n1",  {511'b0, busy}, 512'd1);
        check("t1_start_n1", {511'b0, core_start}, 512'd1);
        repeat (11) @(negedge clk);
        check("t1_busy_n12", {511'b0, busy}, 512'd1);
        @(negedge clk);
        check("t1_busy_n13", {511'b0, busy}, 512'b0);
        check("t1_found",    {511'b0, found}, 512'd1);
        check("t1_fnonce",   {480'b0, found_nonce}, 512'd5);
        check("t1_fhash",    {256'b0, found_hash}, 512'd1);
        check("t1_count",    {480'b0, hash_count}, {480'b0, exp_hc(1)});
        check("t1_starts",   512'(start_cnt - s0), 512'd1);

        // Wrap-around exhaustion.
        cfg_nonce_start = 32'hFFFF_FFFE; cfg_nonce_end = 32'd1; cfg_target = '0;
        sb.push_back(blk_with(tmpl, 32'hFFFF_FFFE));
        sb.push_back(blk_with(tmpl, 32'hFFFF_FFFF));
        sb.push_back(blk_with(tmpl, 32'h0000_0000));
        sb.push_back(blk_with(tmpl, 32'h0000_0001));
        pulse_go();
        wait_idle(100);
        check("t2_exhausted", {511'b0, exhausted}, 512'd1);
        check("t2_found",     {511'b0, found}, 512'b0);
        check("t2_count",     {480'b0, hash_count}, {480'b0, exp_hc(4)});
        check("t2_cur",       {480'b0, cur_nonce}, 512'd1);
        check("t2_sb_empty",  512'(sb.size()), 512'd0);

        // Abort while idle is ignored.
        @(negedge clk) abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_abort_idle", {510'b0, aborted, busy}, 512'b0);
        check("t5_exh_held",   {511'b0, exhausted}, 512'd1);

        // Mid-range hit; go during WAIT with altered config must change nothing.
        hash_mode = 1'b1;
        cfg_nonce_start = 32'd10; cfg_nonce_end = 32'd20; cfg_target = {32'd12, 224'h0};
        sb.push_back(blk_with(tmpl, 32'd10));
        sb.push_back(blk_with(tmpl, 32'd11));
        pulse_go();
        repeat (3) @(negedge clk);
        cfg_block = ~tmpl; cfg_nonce_end = 32'd10; cfg_target = '0;
        go = 1'b1;
        @(negedge clk) go = 1'b0;
        cfg_block = tmpl; cfg_nonce_end = 32'd20; cfg_target = {32'd12, 224'h0};
        wait_idle(100);
        check("t3_found",    {511'b0, found}, 512'd1);
        check("t3_exh",      {511'b0, exhausted}, 512'b0);
        check("t3_fnonce",   {480'b0, found_nonce}, 512'd11);
        check("t3_fhash",    {256'b0, found_hash}, {256'b0, 32'd11, 224'h0});
        check("t3_count",    {480'b0, hash_count}, {480'b0, exp_hc(2)});
        repeat (4) @(negedge clk);
        check("t3_sb_empty", 512'(sb.size()), 512'd0);

        // Abort during WAIT; the in-flight hash would hit but is discarded.
        hash_mode = 1'b0;
        cfg_nonce_start = 32'd100; cfg_nonce_end = 32'd200; cfg_target = '1;
        sb.push_back(blk_with(tmpl, 32'd100));
        s0 = start_cnt;
        pulse_go();
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        repeat (7) @(negedge clk);
        check("t4_busy_chk",  {510'b0, busy, aborted}, 512'd2);
        @(negedge clk);
        check("t4_aborted",   {511'b0, aborted}, 512'd1);
        check("t4_busy",      {511'b0, busy}, 512'b0);
        check("t4_found",     {511'b0, found}, 512'b0);
        check("t4_count",     {480'b0, hash_count}, {480'b0, exp_hc(1)});
        repeat (15) @(negedge clk);
        check("t4_starts",    512'(start_cnt - s0), 512'd1);

        // Asynchronous reset in the middle of WAIT.
        cfg_nonce_start = 32'd50; cfg_nonce_end = 32'd60; cfg_target = '0;
        sb.push_back(blk_with(tmpl, 32'd50));
        pulse_go();
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("t6_busy",      {511'b0, busy}, 512'b0);
        check("t6_core_data", core_data, 512'b0);
        check("t6_outs",      {478'b0, core_start, aborted, cur_nonce}, 512'b0);
        check("t6_count",     {480'b0, hash_count}, 512'b0);
        @(negedge clk) reset = 1'b0;
        repeat (12) @(negedge clk);
        check("t6_done_ign",  {479'b0, busy, hash_count}, 512'b0);

        cfg_nonce_start = 32'd7; cfg_nonce_end = 32'd7; cfg_target = '1;
        sb.push_back(blk_with(tmpl, 32'd7));
        pulse_go();
        wait_idle(100);
        check("t6_found",     {511'b0, found}, 512'd1);
        check("t6_fnonce",    {480'b0, found_nonce}, 512'd7);
        check("t6_count2",    {480'b0, hash_count}, {480'b0, exp_hc(1)});
        check("end_sb_empty", 512'(sb.size()), 512'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
